// File: rtl/fb_pkg.sv
// Frame-buffer shared definitions: geometry, port widths and arbiter state encoding.
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Wrapping frame address counter with sync load-to-zero and a wrap pulse.
module fb_addr_counter
    import fb_pkg::*;
#(
    parameter int W   = FB_ADDR_W,
    parameter int MAX = FB_PIXELS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         zero,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] q;

    // zero together with inc means "use address 0 now, continue from 1"
    assign count = zero ? '0 : q;
    assign wrap  = inc && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (inc) begin
            q <= wrap ? '0 : count + W'(1);
        end else if (zero) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display read > clear fill > camera write,
// with one registered issue stage towards the BRAM.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int NUM_PIXELS = FB_PIXELS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic              wr_sof,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              frame_done,
    output logic              bram_read,
    output logic              bram_write,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    fb_state_t         state;
    logic [DATA_W-1:0] clr_col;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;
    logic              wr_wrap;
    logic              wr_zero;
    logic              clr_fire;
    logic              clr_wrap;
    logic              clr_done;
    logic              clr_go;

    assign rd_gnt   = rd_req;
    assign rd_data  = bram_rdata;
    assign clr_busy = (state == CLEAR);
    assign wr_ready = !rd_req && (state == IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign clr_fire = !rd_req && (state == CLEAR);
    assign clr_done = clr_fire && clr_wrap;
    assign clr_go   = clr_start && (state == IDLE);

    // a finished clear realigns the camera stream to the top of the frame
    assign wr_zero = (wr_fire && wr_sof) || clr_done;

    fb_addr_counter #(
        .W   (ADDR_W),
        .MAX (NUM_PIXELS)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .zero  (wr_zero),
        .inc   (wr_fire),
        .count (wr_addr),
        .wrap  (wr_wrap)
    );

    fb_addr_counter #(
        .W   (ADDR_W),
        .MAX (NUM_PIXELS)
    ) u_clr_ptr (
        .clk   (clk),
        .reset (reset),
        .zero  (clr_go),
        .inc   (clr_fire),
        .count (clr_addr),
        .wrap  (clr_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_col    <= '0;
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
            bram_read  <= 1'b0;
            bram_write <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            rd_valid   <= bram_read;
            bram_read  <= rd_req;
            bram_write <= clr_fire || wr_fire;
            frame_done <= wr_fire && wr_wrap;

            if (rd_req) begin
                bram_addr <= rd_addr;
            end else if (clr_fire) begin
                bram_addr  <= clr_addr;
                bram_wdata <= clr_col;
            end else if (wr_fire) begin
                bram_addr  <= wr_addr;
                bram_wdata <= wr_data;
            end

            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_col <= clr_color;
                    end
                end
                CLEAR: begin
                    if (clr_done) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter on a reduced frame, with a BRAM model and a
// transaction-level reference of the arbitration rules.
module tb_fb_port_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;
    localparam int NP = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic          wr_sof;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          frame_done;
    logic          bram_read;
    logic          bram_write;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .NUM_PIXELS (NP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_sof     (wr_sof),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .frame_done (frame_done),
        .bram_read  (bram_read),
        .bram_write (bram_write),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    // synchronous single-port BRAM model
    logic [DW-1:0] mem [NP];
    logic          init_en;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < NP; i++) mem[i] <= '0;
            mem[1234] <= 12'hABC;
        end else if (bram_write && bram_addr < NP) begin
            mem[bram_addr] <= bram_wdata;
        end
        if (bram_read && bram_addr < NP) bram_rdata <= mem[bram_addr];
    end

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wr_cnt = 0;

    // reference: frame contents, camera pointer, clear progress
    logic [DW-1:0] sh [NP];
    int            m_wptr;
    int            m_cidx;
    bit            m_clr;
    logic [DW-1:0] m_ccol;
    bit            e_rv;
    logic [DW-1:0] e_rdata;

    typedef struct {
        bit            rd;
        int            raddr;
        bit            wv;
        bit            sof;
        logic [DW-1:0] wd;
        bit            x_rd;
        bit            x_wr;
        int            x_addr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        rd_req    = 1'b0;
        rd_addr   = '0;
        wr_valid  = 1'b0;
        wr_sof    = 1'b0;
        wr_data   = '0;
        clr_start = 1'b0;
        clr_color = '0;
    endtask

    task automatic model_reset();
        m_wptr = 0;
        m_cidx = 0;
        m_clr  = 1'b0;
        e_rv   = 1'b0;
    endtask

    // one clock: check comb outputs, predict the issued op, check it after the edge
    task automatic tick();
        bit            was_clr;
        bit            n_read;
        bit            n_write;
        bit            n_done;
        int            n_addr;
        int            a;
        logic [DW-1:0] n_wdata;
        logic [DW-1:0] n_rdata;
        #1;
        chk("rd_gnt", rd_gnt, rd_req);
        chk("wr_ready", wr_ready, !rd_req && !m_clr);
        was_clr = m_clr;
        n_read  = rd_req;
        n_write = 1'b0;
        n_done  = 1'b0;
        n_addr  = 0;
        n_wdata = '0;
        n_rdata = '0;
        if (rd_req) begin
            n_addr  = int'(rd_addr);
            n_rdata = (rd_addr < NP) ? sh[rd_addr] : '0;
        end else if (m_clr) begin
            n_write = 1'b1;
            n_addr  = m_cidx;
            n_wdata = m_ccol;
            m_cidx++;
            if (m_cidx == NP) begin
                m_clr  = 1'b0;
                m_cidx = 0;
                m_wptr = 0;
            end
        end else if (wr_valid) begin
            a       = wr_sof ? 0 : m_wptr;
            n_write = 1'b1;
            n_addr  = a;
            n_wdata = wr_data;
            m_wptr  = (a + 1) % NP;
            n_done  = (a == NP - 1);
        end
        if (n_write) sh[n_addr] = n_wdata;
        if (!was_clr && clr_start) begin
            m_clr  = 1'b1;
            m_cidx = 0;
            m_ccol = clr_color;
        end
        @(posedge clk);
        #1;
        chk("bram_read", bram_read, n_read);
        chk("bram_write", bram_write, n_write);
        if (n_read || n_write) chk("bram_addr", bram_addr, n_addr);
        if (n_write) chk("bram_wdata", bram_wdata, n_wdata);
        chk("frame_done", frame_done, n_done);
        chk("clr_busy", clr_busy, m_clr);
        chk("rd_valid", rd_valid, e_rv);
        if (e_rv) chk("rd_data", rd_data, e_rdata);
        e_rv    = n_read;
        e_rdata = n_rdata;
        if (frame_done) done_cnt++;
        if (bram_write) wr_cnt++;
    endtask

    initial begin
        int bad;
        int cyc;

        tbl[0] = '{1'b1, 7,    1'b1, 1'b0, 12'h111, 1'b1, 1'b0, 7};
        tbl[1] = '{1'b0, 0,    1'b1, 1'b1, 12'h005, 1'b0, 1'b1, 0};
        tbl[2] = '{1'b0, 0,    1'b1, 1'b0, 12'h006, 1'b0, 1'b1, 1};
        tbl[3] = '{1'b0, 0,    1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 0};
        tbl[4] = '{1'b0, 0,    1'b1, 1'b0, 12'h007, 1'b0, 1'b1, 2};
        tbl[5] = '{1'b1, 1999, 1'b1, 1'b0, 12'h008, 1'b1, 1'b0, 1999};
        tbl[6] = '{1'b0, 0,    1'b1, 1'b1, 12'h009, 1'b0, 1'b1, 0};
        tbl[7] = '{1'b0, 0,    1'b1, 1'b0, 12'h00A, 1'b0, 1'b1, 1};

        idle_in();
        reset   = 1'b1;
        init_en = 1'b1;
        for (int i = 0; i < NP; i++) sh[i] = '0;
        sh[1234] = 12'hABC;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        init_en = 1'b0;
        chk("rst_bram_read", bram_read, 0);
        chk("rst_bram_write", bram_write, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_wdata", bram_wdata, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        reset = 1'b0;

        // single read of a preloaded pixel
        rd_req  = 1'b1;
        rd_addr = 19'd1234;
        tick();
        chk("rd1234_addr", bram_addr, 1234);
        idle_in();
        tick();
        chk("rd1234_valid", rd_valid, 1);
        chk("rd1234_data", rd_data, 12'hABC);

        for (int i = 0; i < 8; i++) begin
            idle_in();
            rd_req   = tbl[i].rd;
            rd_addr  = AW'(tbl[i].raddr);
            wr_valid = tbl[i].wv;
            wr_sof   = tbl[i].sof;
            wr_data  = tbl[i].wd;
            tick();
            chk("tbl_read", bram_read, tbl[i].x_rd);
            chk("tbl_write", bram_write, tbl[i].x_wr);
            if (tbl[i].x_rd || tbl[i].x_wr) chk("tbl_addr", bram_addr, tbl[i].x_addr);
        end

        // a full frame from sof, then the wrap to address 0
        idle_in();
        done_cnt = 0;
        for (int i = 0; i < NP; i++) begin
            wr_valid = 1'b1;
            wr_sof   = (i == 0);
            wr_data  = DW'(i) ^ 12'h5A5;
            tick();
        end
        wr_sof  = 1'b0;
        wr_data = 12'h5A5;
        tick();
        chk("wrap_addr", bram_addr, 0);
        chk("frame_done_count", done_cnt, 1);
        bad = 0;
        for (int i = 0; i < NP; i++) if (mem[i] !== (DW'(i) ^ 12'h5A5)) bad++;
        chk("frame_mem_bad", bad, 0);

        // reads held against a waiting camera pixel
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rd_req   = 1'b1;
            rd_addr  = AW'($urandom_range(NP - 1));
            wr_valid = 1'b1;
            wr_data  = 12'h3C3;
            tick();
        end
        chk("starve_writes", wr_cnt, 0);
        rd_req = 1'b0;
        tick();
        chk("resume_write", bram_write, 1);

        // realign mid-stream
        cyc = 0;
        while (m_wptr != 500 && cyc < 2 * NP) begin
            wr_data = DW'($urandom);
            tick();
            cyc++;
        end
        chk("reach_500", m_wptr, 500);
        wr_sof = 1'b1;
        tick();
        chk("sof_addr", bram_addr, 0);
        wr_sof = 1'b0;
        tick();
        chk("post_sof_addr", bram_addr, 1);

        // clear with a coincident camera pixel and periodic reads
        done_cnt  = 0;
        clr_start = 1'b1;
        clr_color = 12'hF00;
        wr_data   = 12'h0F0;
        tick();
        chk("clr_coincident_wr", bram_write, 1);
        clr_start = 1'b0;
        cyc = 0;
        while (m_clr && cyc < 3 * NP) begin
            rd_req  = (cyc % 4 == 3);
            rd_addr = AW'($urandom_range(NP - 1));
            tick();
            cyc++;
        end
        chk("clear_finished", m_clr, 0);
        chk("clr_busy_end", clr_busy, 0);
        rd_req  = 1'b0;
        wr_data = 12'hF00;
        tick();
        chk("post_clear_addr", bram_addr, 0);
        chk("clear_no_done", done_cnt, 0);
        bad = 0;
        for (int i = 0; i < NP; i++) if (mem[i] !== 12'hF00) bad++;
        chk("clear_mem_bad", bad, 0);

        // randomized traffic against the reference
        for (int i = 0; i < 5000; i++) begin
            rd_req    = ($urandom_range(2) == 0);
            rd_addr   = AW'($urandom_range(NP - 1));
            wr_valid  = $urandom_range(1) == 1;
            wr_sof    = ($urandom_range(199) == 0);
            wr_data   = DW'($urandom);
            clr_start = ($urandom_range(1499) == 0);
            clr_color = DW'($urandom);
            tick();
        end
        idle_in();
        cyc = 0;
        while (m_clr && cyc < 2 * NP) begin
            tick();
            cyc++;
        end
        chk("rand_clear_drain", m_clr, 0);

        // reset in the middle of a clear
        clr_start = 1'b1;
        clr_color = 12'h0F0;
        tick();
        clr_start = 1'b0;
        cyc = 0;
        while (m_cidx < 1000 && cyc < 2 * NP) begin
            tick();
            cyc++;
        end
        chk("clr_at_1000", m_cidx, 1000);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", clr_busy, 0);
        chk("rst_mid_write", bram_write, 0);
        chk("rst_mid_read", bram_read, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        wr_valid = 1'b1;
        wr_sof   = 1'b1;
        wr_data  = 12'h123;
        tick();
        chk("rst_sof_addr", bram_addr, 0);
        chk("rst_sof_write", bram_write, 1);
        idle_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
